// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and sizing helpers for the iterative divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  localparam int DEF_WIDTH = 4;
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/trial_subtractor.sv
// trial_subtractor: combinational a - b built from generate/propagate terms like the CLA adder
module trial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  logic [WIDTH-1:0] g, p;
  logic             c;
  assign g = a & ~b;
  assign p = a ^ ~b;
  // a + ~b + 1: carry walks up from a forced carry-in; a missing carry-out means a borrow
  always_comb begin
    c = 1'b1;
    diff = '0;
    for (int k = 0; k < WIDTH; k++) begin
      diff[k] = p[k] ^ c;
      c = g[k] | (p[k] & c);
    end
    borrow = ~c;
  end
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: unsigned restoring divider, one quotient bit per clock behind start/done
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);
  div_state_t       state;
  logic [WIDTH-1:0] r, q, d, r_sh, r_nx, q_nx;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   t;
  logic             borrow, neg;
  assign r_sh = {r[WIDTH-2:0], q[WIDTH-1]};
  trial_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
    .a      ({1'b0, r_sh}),
    .b      ({1'b0, d}),
    .diff   (t),
    .borrow (borrow)
  );
  // with zero-extended operands the sign bit and the borrow agree; either marks a failed trial
  assign neg  = t[WIDTH] | borrow;
  assign r_nx = neg ? r_sh : t[WIDTH-1:0];
  assign q_nx = {q[WIDTH-2:0], ~neg};
  // control FSM with datapath registers; results only load on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          if (d == '0) begin
            Quotient    <= '1;
            Remainder   <= q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            r     <= r_nx;
            q     <= q_nx;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              Quotient    <= q_nx;
              Remainder   <= r_nx;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            d     <= Divisor;
            q     <= Dividend;
            r     <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: randomized and directed divides checked against an arithmetic model
module tb_restoring_divider;
  localparam int W = 4;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] Dividend = '0, Divisor = '0;
  logic [W-1:0] Quotient, Remainder;
  logic         busy, done, div_by_zero;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {logic [W-1:0] q, r; logic z; int lat;} lit_t;
  lit_t lits[16];
  int   n_lit = 0, li = 0, tmo = 0, since = 0;
  int   errors = 0, checks = 0;
  bit   fin = 1'b0, fin_done = 1'b0;

  // reference: one pending job with a countdown; result computed with / and %
  logic         pend = 1'b0, acc = 1'b0, pz = 1'b0, ez = 1'b0, edone = 1'b0, ebusy = 1'b0;
  int           cnt = 0;
  logic [W-1:0] pq = '0, pr = '0, eq = '0, er = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; acc <= 1'b0; cnt <= 0;
      eq <= '0; er <= '0; ez <= 1'b0; edone <= 1'b0; ebusy <= 1'b0;
    end else begin
      acc   <= 1'b0;
      edone <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          pend <= 1'b0; ebusy <= 1'b0; edone <= 1'b1;
          eq <= pq; er <= pr; ez <= pz;
        end else cnt <= cnt - 1;
      end else if (start) begin
        pend  <= 1'b1; ebusy <= 1'b1; acc <= 1'b1;
        cnt   <= (Divisor == 0) ? 1 : W;
        pz    <= (Divisor == 0);
        pq    <= (Divisor == 0) ? '1 : Dividend / Divisor;
        pr    <= (Divisor == 0) ? Dividend : Dividend % Divisor;
      end
    end
  end

  // every cycle: outputs vs model; on done also vs hand-computed literals and latency
  always @(negedge clk) begin
    checks++;
    if ({Quotient, Remainder, div_by_zero, done, busy} !== {eq, er, ez, edone, ebusy}) begin
      errors++;
      $display("FAIL cycle t=%0t got q=%0d r=%0d z=%b done=%b busy=%b want q=%0d r=%0d z=%b done=%b busy=%b",
               $time, Quotient, Remainder, div_by_zero, done, busy, eq, er, ez, edone, ebusy);
    end
    since = acc ? 0 : since + 1;
    if (done && li < n_lit) begin
      checks++;
      if (Quotient !== lits[li].q || Remainder !== lits[li].r || div_by_zero !== lits[li].z || since != lits[li].lat) begin
        errors++;
        $display("FAIL literal%0d got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=%b lat=%0d",
                 li, Quotient, Remainder, div_by_zero, since, lits[li].q, lits[li].r, lits[li].z, lits[li].lat);
      end
      li++;
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      checks++;
      if (li != n_lit || tmo != 0) begin
        errors++;
        $display("FAIL completion got literals_seen=%0d timeouts=%0d want literals_seen=%0d timeouts=0", li, tmo, n_lit);
      end
    end
  end

  task automatic expect_lit(input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input int lat);
    lits[n_lit] = '{q, r, z, lat};
    n_lit++;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; Dividend = a; Divisor = b;
    @(posedge clk); #2;
    start = 1'b0; Dividend = W'($urandom); Divisor = W'($urandom);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 20) tmo++;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #2;
    start_op(a, b);
    wait_done();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    expect_lit(4'd3, 4'd1, 1'b0, 4);  op(4'd13, 4'd4);
    expect_lit(4'd15, 4'd0, 1'b0, 4); op(4'd15, 4'd1);
    expect_lit(4'd1, 4'd0, 1'b0, 4);  op(4'd15, 4'd15);
    expect_lit(4'd0, 4'd3, 1'b0, 4);  op(4'd3, 4'd9);
    expect_lit(4'd0, 4'd0, 1'b0, 4);  op(4'd0, 4'd5);
    expect_lit(4'd15, 4'd7, 1'b1, 1); op(4'd7, 4'd0);
    expect_lit(4'd4, 4'd0, 1'b0, 4);  op(4'd8, 4'd2);
    // second start lands mid-operation and must be ignored
    expect_lit(4'd2, 4'd2, 1'b0, 4);
    @(posedge clk); #2;
    start_op(4'd12, 4'd5);
    @(posedge clk); #2;
    start = 1'b1; Dividend = 4'd9; Divisor = 4'd3;
    @(posedge clk); #2;
    start = 1'b0; Dividend = 4'd1; Divisor = 4'd0;
    wait_done();
    repeat (3) @(posedge clk);
    // back-to-back: next start issued during the DONE cycle
    expect_lit(4'd4, 4'd1, 1'b0, 4); op(4'd9, 4'd2);
    expect_lit(4'd3, 4'd1, 1'b0, 4); start_op(4'd10, 4'd3); wait_done();
    // reset in the middle of an operation
    @(posedge clk); #2;
    start_op(4'd14, 4'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    expect_lit(4'd4, 4'd2, 1'b0, 4); op(4'd14, 4'd3);
    // random start pulses, including ones that land while busy
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 2) == 0);
      Dividend = W'($urandom);
      Divisor = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op(W'(a), W'(b));
    repeat (3) @(posedge clk);
    fin = 1'b1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
